// File: rtl/div_share_arbiter_pkg.sv
// Shared types and constants for the shared-divider arbiter and its tag FIFO.
package div_share_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_TAG_DEPTH = 8;

  localparam int DIVIDEND_W = 40;
  localparam int DIVISOR_W  = 20;
  localparam int RESULT_W   = 48;

  // The quotient sits in the divider result word between these bit positions.
  localparam int QUOT_HI = 41;
  localparam int QUOT_LO = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/div_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each divider result in flight.
module div_tag_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: the storage array has no reset; r_count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, in-order divider among NUM_REQ requesters.
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int TAG_DEPTH = DEF_TAG_DEPTH,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TAG_W     = IDX_W + 1,
  localparam int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DIVIDEND_W-1:0]   req_dividend,
  input  logic [NUM_REQ*DIVISOR_W-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic                            clear,
  output logic                            div_valid,
  output logic [DIVIDEND_W-1:0]           div_dividend,
  output logic [DIVISOR_W-1:0]            div_divisor,
  input  logic                            div_out_valid,
  input  logic [RESULT_W-1:0]             div_out_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DIVIDEND_W-1:0]           rsp_quot,
  output logic                            rsp_divzero,
  output logic                            busy,
  output logic                            proto_err
);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic                    r_div_valid;
  logic [DIVIDEND_W-1:0]   r_div_dividend;
  logic [DIVISOR_W-1:0]    r_div_divisor;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DIVIDEND_W-1:0]   r_rsp_quot;
  logic                    r_rsp_divzero;
  logic                    r_proto_err;

  logic [NUM_REQ-1:0]      w_gnt;
  logic                    w_gnt_any;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic [IDX_W-1:0]        w_cand;
  logic                    w_can_grant;
  logic [DIVIDEND_W-1:0]   w_sel_dividend;
  logic [DIVISOR_W-1:0]    w_sel_divisor;
  logic [TAG_W-1:0]        w_push_tag;
  logic [TAG_W-1:0]        w_head_tag;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_unused_result;

  // A full FIFO blocks the grant even if a result pops it this very cycle.
  assign w_can_grant = (r_state == ST_ARB) && !clear && !w_fifo_full;

  // NOTE: always_comb uses blocking assignments with a default for every output first, so no latch is inferred.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (w_can_grant) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_gnt_any && req[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
      if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign w_sel_dividend  = req_dividend[int'(w_gnt_idx)*DIVIDEND_W +: DIVIDEND_W];
  assign w_sel_divisor   = req_divisor[int'(w_gnt_idx)*DIVISOR_W +: DIVISOR_W];
  assign w_push_tag      = {w_gnt_idx, (w_sel_divisor == '0)};
  assign w_unused_result = ^{div_out_data[RESULT_W-1:QUOT_HI+1], div_out_data[QUOT_LO-1:0]};

  div_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_gnt_any),
    .i_push_data (w_push_tag),
    .i_pop       (div_out_valid),
    .o_head      (w_head_tag),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_div_valid    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_rsp_valid    <= '0;
      r_rsp_quot     <= '0;
      r_rsp_divzero  <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      r_div_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_div_dividend <= w_sel_dividend;
        r_div_divisor  <= w_sel_divisor;
        r_rr_ptr       <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + IDX_W'(1);
      end

      r_rsp_valid <= '0;
      if (div_out_valid) begin
        if (w_fifo_empty) begin
          r_proto_err <= 1'b1;
        end else begin
          r_rsp_valid[w_head_tag[TAG_W-1:1]] <= 1'b1;
          r_rsp_quot    <= div_out_data[QUOT_HI:QUOT_LO];
          r_rsp_divzero <= w_head_tag[0];
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (clear)     r_state <= ST_DRAIN;
          else if (|req) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (clear)                            r_state <= ST_DRAIN;
          else if (req == '0 && w_fifo_empty)   r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // Restart arbitration from requester 0 once every in-flight result is back.
          if (!clear && w_fifo_empty) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt          = w_gnt;
  assign div_valid    = r_div_valid;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_quot     = r_rsp_quot;
  assign rsp_divzero  = r_rsp_divzero;
  assign proto_err    = r_proto_err;
  assign busy         = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; TAG_DEPTH, default 8, maximum outstanding divisions.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, NUM_REQ bits: per-requester division request, held until granted.
REQ-005 SHALL have port req_dividend, input, NUM_REQ x 40 bits: signed dividends.
REQ-006 SHALL have port req_divisor, input, NUM_REQ x 20 bits: signed divisors.
REQ-007 SHALL have port gnt, output, NUM_REQ bits: one-hot grant pulse.
REQ-008 SHALL have port clear, input, 1 bit: synchronous drain-and-restart command.
REQ-009 SHALL have ports div_valid (output, 1 bit), div_dividend (output, 40 bits) and div_divisor (output, 20 bits): issue side to the shared divider.
REQ-010 SHALL have ports div_out_valid (input, 1 bit) and div_out_data (input, 48 bits): divider result.
REQ-011 SHALL have ports rsp_valid (output, NUM_REQ bits, one-hot pulse), rsp_quot (output, 40 bits, signed) and rsp_divzero (output, 1 bit).
REQ-012 SHALL have ports busy (output, 1 bit: state not IDLE or results outstanding) and proto_err (output, 1 bit, sticky).

Function
REQ-013 SHALL implement states IDLE, ARB and DRAIN.
REQ-014 IDLE SHALL go to ARB when any req is high and clear is low.
REQ-015 ARB SHALL go to IDLE when req is zero and no results are outstanding.
REQ-016 Any state SHALL go to DRAIN when clear is high; DRAIN SHALL go to IDLE when the tag FIFO is empty.
REQ-017 In ARB, with the tag FIFO not full, the block SHALL grant at most one requester per cycle, round-robin, starting search at rr_ptr.
REQ-018 After granting requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; it SHALL be unchanged when no grant is made.
REQ-019 gnt SHALL be combinational in the selection cycle N.
REQ-020 At edge N the block SHALL latch the granted operands into div_dividend/div_divisor and assert div_valid for exactly cycle N+1.
REQ-021 At the same edge it SHALL push {requester index, divisor==0} into the tag FIFO.
REQ-022 A requester SHALL drop req, or present a new operand set, in the cycle after gnt.
REQ-023 Full FIFO SHALL block grants even when a pop occurs in the same cycle.
REQ-024 No grants SHALL occur in IDLE or DRAIN.
REQ-025 On div_out_valid, the block SHALL pop the FIFO head; in the next cycle it SHALL pulse rsp_valid[head index] for one cycle, with rsp_quot = div_out_data[41:2] and rsp_divzero = head flag.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-027 Results SHALL be delivered in issue order; the divider is assumed in-order with fixed latency.
REQ-028 div_out_valid with an empty FIFO SHALL set proto_err, drop the result and produce no rsp_valid.
REQ-029 proto_err SHALL clear only on reset.
REQ-030 Divisor 0 SHALL still be issued so the ordering is preserved; only the flag marks it.
REQ-031 During DRAIN, results SHALL continue to be delivered; on reaching IDLE, rr_ptr SHALL become 0.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE; rr_ptr 0; FIFO empty; gnt, div_valid, rsp_valid, rsp_divzero, busy and proto_err 0; div_dividend, div_divisor and rsp_quot 0.
REQ-033 Reset mid-operation SHALL discard outstanding tags; later divider results SHALL be treated per REQ-028.

Structure
REQ-034 A shared package SHALL hold the state enum, NUM_REQ, TAG_DEPTH, widths 40/20/48, and quotient slice bounds 41 and 2.
REQ-035 The tag FIFO SHALL be one sub-module, div_tag_fifo: width clog2(NUM_REQ)+1, depth TAG_DEPTH, full/empty/count outputs.

Verification
REQ-036 Single request: req[2]=1 with 1000/4, divider latency 5 -> gnt[2] in the request cycle; div_valid 1 cycle later; rsp_valid[2] 6 cycles after issue.
REQ-037 Simultaneous requests: all four req high from reset -> grants 0,1,2,3 on consecutive cycles, then rsp_valid 0,1,2,3 in that order.
REQ-038 Backpressure: divider latency 20, requests held -> exactly 8 grants, then none until the first result returns, then one grant per result.
REQ-039 Divide by zero: divisor 0 from requester 1 -> issued, rsp_valid[1] with rsp_divzero=1; neighbouring results have rsp_divzero=0.
REQ-040 Clear: clear pulsed with 3 outstanding and requests pending -> no further gnt; 3 responses delivered; IDLE with rr_ptr 0; requester 0 granted first afterward.
REQ-041 Reset and spurious result: rst_n low with 3 outstanding, then 3 div_out_valid -> no rsp_valid; proto_err=1 after the first.
